// File: rtl/add_accumulator.sv
// ---------------------------------------------------------------------------
// add_accumulator
//  Sums a stream of len words using an external combinational adder.
//  Returns {carry count, sum} through a valid/ready result handshake.
//
//  Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start, len        begin an accumulation of len words (sampled in IDLE)
//   in_valid/in_ready input word handshake, in_data = word
//   add_a/add_b/cin   operands driven to the external adder
//   add_sum/add_cout  result returned by the external adder
//   res_valid/ready   result handshake
//   res_sum           low WIDTH bits of the total
//   res_carries       saturating count of adder carry-outs
//   res_ovf           sticky: a carry arrived while the counter was full
//   busy              high while accumulating or holding a result
// ---------------------------------------------------------------------------
module add_accumulator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8,
    // len width; defaults to the carry counter width
    parameter int unsigned LEN_W = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic [CNT_W-1:0] res_carries,
    output logic             res_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] rem_q,   rem_d;
    logic             ovf_q,   ovf_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                // in_ready is constant high here, so in_valid alone is the transfer
                if (in_valid) begin
                    acc_d = add_sum;
                    rem_d = rem_q - LEN_W'(1);
                    if (add_cout) begin
                        // counter saturates; overflow is remembered instead
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // start is deliberately not looked at until back in IDLE
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded directly from registers; adder operands pass in_data through
    always_comb begin
        in_ready    = (state_q == S_ACC);
        add_a       = acc_q;
        add_b       = (state_q == S_ACC) ? in_data : '0;
        add_cin     = 1'b0;
        res_valid   = (state_q == S_DONE);
        res_sum     = acc_q;
        res_carries = cnt_q;
        res_ovf     = ovf_q;
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_add_accumulator.sv
// ---------------------------------------------------------------------------
// tb_add_accumulator
//  Bench for add_accumulator. Provides the 32-bit adder behaviourally and
//  compares results against a total computed with wide integer arithmetic.
//  A second instance with a 2-bit carry counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_add_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // main instance (CNT_W = 8)
    logic        start, in_valid, in_ready, add_cin, add_cout;
    logic        res_valid, res_ready, res_ovf, busy;
    logic [7:0]  len, res_carries;
    logic [31:0] in_data, add_a, add_b, add_sum, res_sum;

    // saturation instance (CNT_W = 2, 8-bit len)
    logic        b_start, b_in_valid, b_in_ready, b_add_cin, b_add_cout;
    logic        b_res_valid, b_res_ready, b_res_ovf, b_busy;
    logic [7:0]  b_len;
    logic [1:0]  b_res_carries;
    logic [31:0] b_in_data, b_add_a, b_add_b, b_add_sum, b_res_sum;

    // behavioural stand-ins for bit32_adder
    assign {add_cout, add_sum}     = 33'(add_a) + 33'(add_b) + 33'(add_cin);
    assign {b_add_cout, b_add_sum} = 33'(b_add_a) + 33'(b_add_b) + 33'(b_add_cin);

    add_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_carries(res_carries), .res_ovf(res_ovf), .busy(busy)
    );

    add_accumulator #(.WIDTH(32), .CNT_W(2), .LEN_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .add_a(b_add_a), .add_b(b_add_b), .add_cin(b_add_cin),
        .add_sum(b_add_sum), .add_cout(b_add_cout),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .res_sum(b_res_sum),
        .res_carries(b_res_carries), .res_ovf(b_res_ovf), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] words[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide sum of all words; carries are whatever spills past bit 31
    task automatic ref_result(input int cnt_w, output logic [31:0] s,
                              output logic [7:0] c, output logic o);
        longint unsigned total;
        longint unsigned carries;
        longint unsigned cmax;
        total = 0;
        foreach (words[i]) total += longint'(words[i]);
        carries = total >> 32;
        cmax    = (longint'(1) << cnt_w) - 1;
        s = total[31:0];
        c = (carries > cmax) ? cmax[7:0] : carries[7:0];
        o = (carries > cmax);
    endtask

    // One full accumulation on the main instance using the words queue
    task automatic do_op(input int gap_pct, input int hold_cyc, input bit start_in_done);
        logic [31:0] es;
        logic [7:0]  ec;
        logic        eo;
        int          n, idx, cyc;
        bit          v;
        n = words.size();
        ref_result(8, es, ec, eo);
        start = 1'b1;
        len   = 8'(n);
        tick;
        start = 1'b0;
        len   = 8'd0;
        check("busy_after_start", busy, 1);
        if (n == 0) begin
            check("len0_res_valid", res_valid, 1);
            check("len0_in_ready", in_ready, 0);
        end else begin
            check("acc_in_ready", in_ready, 1);
            check("acc_res_valid", res_valid, 0);
            idx = 0;
            cyc = 0;
            while (idx < n && cyc < 2000) begin
                v = ($urandom_range(99) >= 32'(gap_pct));
                in_valid = v;
                in_data  = v ? words[idx] : $urandom;
                tick;
                cyc++;
                in_valid = 1'b0;
                if (v) idx++;
                if (idx < n) begin
                    check("acc_in_ready_mid", in_ready, 1);
                    check("acc_res_valid_mid", res_valid, 0);
                end
            end
            check("all_words_taken", 64'(idx), 64'(n));
            check("done_latency_valid", res_valid, 1);
            check("done_in_ready", in_ready, 0);
        end
        check("res_sum", res_sum, es);
        check("res_carries", res_carries, ec);
        check("res_ovf", res_ovf, eo);
        res_ready = 1'b0;
        for (int i = 0; i < hold_cyc; i++) begin
            start    = start_in_done && (i == 0);
            len      = 8'd7;
            in_valid = 1'($urandom);
            in_data  = $urandom;
            tick;
            start    = 1'b0;
            in_valid = 1'b0;
            check("hold_valid", res_valid, 1);
            check("hold_sum", res_sum, es);
            check("hold_carries", res_carries, ec);
            check("hold_busy", busy, 1);
        end
        res_ready = 1'b1;
        start     = start_in_done;
        len       = 8'd3;
        tick;
        res_ready = 1'b0;
        start     = 1'b0;
        check("drop_valid", res_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        tick;
        check("start_ignored_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; len = 0; in_valid = 0; in_data = 0; res_ready = 0;
        b_start = 0; b_len = 0; b_in_valid = 0; b_in_data = 0; b_res_ready = 0;

        // reset held for two clocks
        tick;
        tick;
        rst_n = 1'b1;
        check("rst_res_valid", res_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_carries", res_carries, 0);
        check("rst_ovf", res_ovf, 0);
        check("rst_b_res_valid", b_res_valid, 0);

        // two words back to back with a single carry
        words = '{32'hDDDDDDDD, 32'h77777777};
        do_op(0, 0, 1'b0);
        check("dir_sum_const", res_sum, 64'h55555554);
        check("dir_carries_const", res_carries, 1);

        // zero-length accumulation
        words.delete();
        do_op(0, 1, 1'b0);

        // gaps, held result, start pulsed while holding
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        do_op(40, 3, 1'b1);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            words.delete();
            for (int i = 0; i < int'($urandom_range(24, 1)); i++) begin
                words.push_back((r % 2 == 0) ? $urandom : (32'hF0000000 | $urandom));
            end
            do_op(int'($urandom_range(50)), int'($urandom_range(4)), 1'($urandom));
        end

        // saturation on the 2-bit counter: five all-ones words
        b_start = 1'b1;
        b_len   = 8'd5;
        tick;
        b_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'hFFFFFFFF;
            tick;
        end
        b_in_valid = 1'b0;
        check("sat_res_valid", b_res_valid, 1);
        check("sat_res_sum", b_res_sum, 64'hFFFFFFFB);
        check("sat_res_carries", b_res_carries, 3);
        check("sat_res_ovf", b_res_ovf, 1);
        b_res_ready = 1'b1;
        tick;
        b_res_ready = 1'b0;
        check("sat_drop_valid", b_res_valid, 0);

        // reset in the middle of an accumulation
        start = 1'b1;
        len   = 8'd3;
        tick;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = $urandom;
        tick;
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_res_sum", res_sum, 0);
        check("midrst_carries", res_carries, 0);
        tick;
        check("midrst_stay_idle", res_valid, 0);
        words = '{32'h12345678};
        do_op(0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
